// File: rtl/mac_job_sequencer_if.sv
// Connection bundle for the MAC job sequencer: job push port, result port
// and the Start/Done handshake towards the Multiply_Accumulate unit.
interface mac_job_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Job push side (host/PIO register block)
  logic              Job_valid_in;
  logic              Job_ready_out;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] X_in;
  logic [DATA_W-1:0] B_in;

  // Result side
  logic              Res_valid_out;
  logic              Res_ready_in;
  logic [DATA_W-1:0] Res_data_out;
  logic              Res_timeout_out;

  // MAC handshake side
  logic              Mac_start_out;
  logic              Mac_done_out;
  logic [DATA_W-1:0] Mac_A_out;
  logic [DATA_W-1:0] Mac_X_out;
  logic [DATA_W-1:0] Mac_B_out;
  logic [DATA_W-1:0] Mac_Y_in;
  logic              Mac_valid_in;

  // Status
  logic              Busy_out;
  logic [CNT_W-1:0]  Job_count_out;

  // Sequencer view
  modport slave (
    input  Job_valid_in, A_in, X_in, B_in,
    input  Res_ready_in,
    input  Mac_Y_in, Mac_valid_in,
    output Job_ready_out,
    output Res_valid_out, Res_data_out, Res_timeout_out,
    output Mac_start_out, Mac_done_out, Mac_A_out, Mac_X_out, Mac_B_out,
    output Busy_out, Job_count_out
  );

  // Host / MAC environment view
  modport master (
    output Job_valid_in, A_in, X_in, B_in,
    output Res_ready_in,
    output Mac_Y_in, Mac_valid_in,
    input  Job_ready_out,
    input  Res_valid_out, Res_data_out, Res_timeout_out,
    input  Mac_start_out, Mac_done_out, Mac_A_out, Mac_X_out, Mac_B_out,
    input  Busy_out, Job_count_out
  );
endinterface

// File: rtl/mac_job_sequencer.sv
// Buffers (A, X, B) operand triplets in a small FIFO and issues them one at
// a time to the MAC using its Start/Valid/Done handshake. Each job produces
// one result on a valid/ready port, either the captured Y or a timeout abort.
module mac_job_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic                CLK,
  input logic                RST,
  mac_job_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FLUSH, START, WAIT, OUT} state_t;

  state_t state;
  state_t next_state;

  // Job FIFO
  logic [3*DATA_W-1:0] job_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    job_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [3*DATA_W-1:0] head_job;

  // FSM control strobes
  logic load_job;
  logic flush_done;
  logic finish_ok;
  logic finish_tmo;
  logic res_accept;
  logic tmo_hit;

  // Registered outputs
  logic [TMO_W-1:0]  tmo_count;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_x;
  logic [DATA_W-1:0] mac_b;
  logic [DATA_W-1:0] res_data;
  logic              mac_done;
  logic              res_valid;
  logic              res_timeout;

  assign fifo_full  = (job_count == CNT_W'(DEPTH));
  assign fifo_empty = (job_count == '0);
  assign push       = bus.Job_valid_in && !fifo_full;
  assign pop        = finish_ok || finish_tmo;
  assign head_job   = job_mem[rd_ptr];
  assign tmo_hit    = (tmo_count == TMO_W'(TIMEOUT));

  // Operand storage; only written on an accepted push, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      job_mem[wr_ptr] <= {bus.A_in, bus.X_in, bus.B_in};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      job_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   job_count <= job_count + 1'b1;
        2'b01:   job_count <= job_count - 1'b1;
        default: job_count <= job_count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a stale MAC Valid in IDLE is always flushed before
  // a new Start so the MAC never sees Start while it still holds a result.
  always_comb begin
    next_state = state;
    load_job   = 1'b0;
    flush_done = 1'b0;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    res_accept = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Mac_valid_in) begin
          next_state = FLUSH;
          flush_done = 1'b1;
        end else if (!fifo_empty) begin
          next_state = START;
          load_job   = 1'b1;
        end
      end
      FLUSH: begin
        next_state = IDLE;
      end
      START: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (bus.Mac_valid_in) begin
          next_state = OUT;
          finish_ok  = 1'b1;
        end else if (tmo_hit) begin
          next_state = OUT;
          finish_tmo = 1'b1;
        end
      end
      OUT: begin
        if (bus.Res_ready_in) begin
          next_state = IDLE;
          res_accept = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // MAC operand latch, timeout counter, Done pulse and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mac_a       <= '0;
      mac_x       <= '0;
      mac_b       <= '0;
      tmo_count   <= '0;
      mac_done    <= 1'b0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      mac_done <= flush_done || finish_ok || finish_tmo;

      if (load_job) begin
        {mac_a, mac_x, mac_b} <= head_job;
        tmo_count             <= '0;
      end else if ((state == WAIT) && !pop) begin
        tmo_count <= tmo_count + 1'b1;
      end

      if (finish_ok) begin
        res_data    <= bus.Mac_Y_in;
        res_timeout <= 1'b0;
        res_valid   <= 1'b1;
      end else if (finish_tmo) begin
        res_data    <= '0;
        res_timeout <= 1'b1;
        res_valid   <= 1'b1;
      end else if (res_accept) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.Job_ready_out   = !fifo_full;
  assign bus.Job_count_out   = job_count;
  assign bus.Mac_start_out   = (state == START);
  assign bus.Mac_done_out    = mac_done;
  assign bus.Mac_A_out       = mac_a;
  assign bus.Mac_X_out       = mac_x;
  assign bus.Mac_B_out       = mac_b;
  assign bus.Res_valid_out   = res_valid;
  assign bus.Res_data_out    = res_data;
  assign bus.Res_timeout_out = res_timeout;
  assign bus.Busy_out        = (state != IDLE);

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Self-checking bench for mac_job_sequencer: a behavioural MAC with random
// latency, a job/result scoreboard and directed scenarios around it.
module tb_mac_job_sequencer;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  typedef struct { logic [31:0] a; logic [31:0] x; logic [31:0] b; } job_t;
  typedef struct { logic tmo; logic [31:0] data; } res_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  mac_job_sequencer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  mac_job_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Scoreboard state
  job_t issue_q[$];
  res_t res_q[$];
  int   mac_lat_q[$];
  int   model_count = 0;

  // Environment modes: MAC 0=never answers, 1=fixed latency, 2=random latency
  int mac_mode      = 1;
  int mac_fixed_lat = 3;
  // Result consumer: 0=always ready, 1=held low, 2=random
  int ready_mode    = 0;

  // Monitor statistics
  int cyc        = 0;
  int start_cyc  = 0;
  int start_cnt  = 0;
  int done_cnt   = 0;
  int flush_cnt  = 0;
  int result_cnt = 0;

  // Single comparison point for the whole bench.
  task automatic check_output(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Q15.16 multiply-accumulate as the MAC would compute it.
  function automatic logic [31:0] mac_ref(input logic [31:0] a, input logic [31:0] x, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sx;
    logic signed [63:0] prod;
    sa   = $signed(a);
    sx   = $signed(x);
    prod = sa * sx;
    return prod[47:16] + b;
  endfunction

  // Behavioural MAC: arms on Start, raises Valid after its latency, holds it until Done.
  initial begin
    int          remaining;
    logic        armed;
    logic [31:0] y_hold;
    remaining        = 0;
    armed            = 1'b0;
    y_hold           = '0;
    bus.Mac_valid_in = 1'b0;
    bus.Mac_Y_in     = '0;
    forever begin
      @(negedge CLK);
      if (bus.Mac_done_out) begin
        bus.Mac_valid_in = 1'b0;
        armed            = 1'b0;
      end else if (bus.Mac_start_out) begin
        if (mac_mode != 0) begin
          remaining = (mac_mode == 1) ? mac_fixed_lat : $urandom_range(1, 7);
          mac_lat_q.push_back(remaining);
          y_hold = mac_ref(bus.Mac_A_out, bus.Mac_X_out, bus.Mac_B_out);
          armed  = 1'b1;
        end
      end else if (armed && !bus.Mac_valid_in) begin
        remaining--;
        if (remaining == 0) begin
          bus.Mac_Y_in     = y_hold;
          bus.Mac_valid_in = 1'b1;
        end
      end
    end
  end

  // Result consumer ready generator.
  initial begin
    bus.Res_ready_in = 1'b1;
    forever begin
      @(negedge CLK);
      case (ready_mode)
        0:       bus.Res_ready_in = 1'b1;
        1:       bus.Res_ready_in = 1'b0;
        default: bus.Res_ready_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Cycle monitor: checks occupancy, Start/Done rules, operand and result stability.
  initial begin
    logic        prev_valid;
    logic        prev_done;
    logic        prev_tmo;
    logic [31:0] prev_data;
    logic        in_flight;
    job_t        j;
    job_t        ops;
    res_t        r;
    int          exp_lat;
    prev_valid = 1'b0;
    prev_done  = 1'b0;
    prev_tmo   = 1'b0;
    prev_data  = '0;
    in_flight  = 1'b0;
    ops        = '{32'd0, 32'd0, 32'd0};
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (RST) begin
        prev_valid = 1'b0;
        prev_done  = 1'b0;
        in_flight  = 1'b0;
      end else begin
        if (bus.Mac_start_out) begin
          start_cnt++;
          start_cyc = cyc;
          check_output("start_done_overlap", bus.Mac_done_out, 1'b0);
          check_output("start_while_result", bus.Res_valid_out, 1'b0);
          if (issue_q.size() == 0) begin
            check_output("start_without_job", 1'b1, 1'b0);
          end else begin
            j = issue_q.pop_front();
            check_output("mac_ops_issued", {bus.Mac_A_out, bus.Mac_X_out, bus.Mac_B_out}, {j.a, j.x, j.b});
          end
          ops       = '{bus.Mac_A_out, bus.Mac_X_out, bus.Mac_B_out};
          in_flight = 1'b1;
        end else if (in_flight) begin
          check_output("mac_ops_stable", {bus.Mac_A_out, bus.Mac_X_out, bus.Mac_B_out}, {ops.a, ops.x, ops.b});
        end

        if (bus.Mac_done_out) begin
          done_cnt++;
          check_output("done_one_cycle", prev_done, 1'b0);
          if (!in_flight) flush_cnt++;
          in_flight = 1'b0;
        end

        if (bus.Res_valid_out && !prev_valid) begin
          result_cnt++;
          model_count--;
          check_output("done_with_result", bus.Mac_done_out, 1'b1);
          if (res_q.size() == 0) begin
            check_output("unexpected_result", 1'b1, 1'b0);
          end else begin
            r = res_q.pop_front();
            check_output("res_timeout", bus.Res_timeout_out, r.tmo);
            check_output("res_data", bus.Res_data_out, r.data);
            if (r.tmo) exp_lat = TIMEOUT + 2;
            else if (mac_lat_q.size() > 0) exp_lat = mac_lat_q.pop_front() + 1;
            else exp_lat = -1;
            check_output("res_latency", cyc - start_cyc, exp_lat);
          end
        end else if (prev_valid) begin
          check_output("res_handshake", bus.Res_valid_out, !bus.Res_ready_in);
          if (bus.Res_valid_out) begin
            check_output("res_held", {bus.Res_timeout_out, bus.Res_data_out}, {prev_tmo, prev_data});
          end
        end

        check_output("job_count", bus.Job_count_out, model_count);
        check_output("job_ready", bus.Job_ready_out, model_count < DEPTH);

        prev_valid = bus.Res_valid_out;
        prev_done  = bus.Mac_done_out;
        prev_tmo   = bus.Res_timeout_out;
        prev_data  = bus.Res_data_out;
      end
    end
  end

  // Drive one job for one cycle; acceptance is decided by the model occupancy.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] x, input logic [31:0] b,
                                input logic [31:0] exp_data, input logic exp_tmo, output logic acc);
    @(negedge CLK);
    bus.Job_valid_in = 1'b1;
    bus.A_in         = a;
    bus.X_in         = x;
    bus.B_in         = b;
    acc              = (model_count < DEPTH);
    @(posedge CLK);
    if (acc) begin
      model_count++;
      issue_q.push_back('{a, x, b});
      res_q.push_back('{exp_tmo, exp_data});
    end
  endtask

  task automatic stop_push();
    @(negedge CLK);
    bus.Job_valid_in = 1'b0;
  endtask

  // Wait until every expected result is out and the sequencer is idle.
  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while ((res_q.size() != 0 || bus.Busy_out) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check_output("drain_bound", n >= budget, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_job_ready"}, bus.Job_ready_out, 1'b1);
    check_output({tag, "_job_count"}, bus.Job_count_out, 0);
    check_output({tag, "_res_valid"}, bus.Res_valid_out, 1'b0);
    check_output({tag, "_res_data"}, bus.Res_data_out, 0);
    check_output({tag, "_res_timeout"}, bus.Res_timeout_out, 1'b0);
    check_output({tag, "_start"}, bus.Mac_start_out, 1'b0);
    check_output({tag, "_done"}, bus.Mac_done_out, 1'b0);
    check_output({tag, "_mac_ops"}, {bus.Mac_A_out, bus.Mac_X_out, bus.Mac_B_out}, 0);
    check_output({tag, "_busy"}, bus.Busy_out, 1'b0);
  endtask

  task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] x,
                            input logic [31:0] b, input logic [31:0] exp_data, input logic exp_tmo);
    int   s0;
    int   d0;
    logic acc;
    s0 = start_cnt;
    d0 = done_cnt;
    apply_stimulus(a, x, b, exp_data, exp_tmo, acc);
    stop_push();
    wait_drained(200);
    check_output({tag, "_starts"}, start_cnt - s0, 1);
    check_output({tag, "_dones"}, done_cnt - d0, 1);
    check_output({tag, "_busy"}, bus.Busy_out, 1'b0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got time limit, expected end of test");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Main scenario sequence.
  initial begin
    logic        acc;
    logic [31:0] a;
    logic [31:0] x;
    logic [31:0] b;
    int          s0;
    int          d0;
    int          f0;
    int          r0;
    int          n;

    bus.Job_valid_in = 1'b0;
    bus.A_in         = '0;
    bus.X_in         = '0;
    bus.B_in         = '0;

    // Power-on reset
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    RST = 1'b0;
    $display("[TB] reset released");

    // Single job and negative-value job, MAC latency 3
    mac_mode      = 1;
    mac_fixed_lat = 3;
    run_single("single", 32'h0001_8000, 32'h0002_4000, 32'h0000_C000, 32'h0004_2000, 1'b0);
    run_single("negative", 32'hFFFF_0000, 32'h0003_0000, 32'h0001_4000, 32'hFFFE_4000, 1'b0);

    // Burst of 5 with results stalled
    $display("[TB] burst with backpressure");
    ready_mode = 1;
    repeat (2) @(negedge CLK);
    s0 = start_cnt;
    r0 = result_cnt;
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      x = $urandom;
      b = $urandom;
      apply_stimulus(a, x, b, mac_ref(a, x, b), 1'b0, acc);
      if (i == 3) begin
        #1;
        check_output("burst_full_ready", bus.Job_ready_out, 1'b0);
        check_output("burst_full_count", bus.Job_count_out, 4);
      end
    end
    stop_push();
    n = 0;
    while (result_cnt == r0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_output("burst_first_result_bound", n >= 50, 1'b0);
    check_output("burst_count_after_pop", bus.Job_count_out, 3);
    repeat (10) @(negedge CLK);
    check_output("burst_single_start_while_stalled", start_cnt - s0, 1);
    check_output("burst_stall_valid", bus.Res_valid_out, 1'b1);
    ready_mode = 0;
    wait_drained(400);
    check_output("burst_starts", start_cnt - s0, 4);

    // Timeout: MAC never answers, then a normal job follows
    $display("[TB] timeout path");
    mac_mode = 0;
    run_single("timeout", 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 1'b1);
    mac_mode = 1;
    a = $urandom;
    x = $urandom;
    b = $urandom;
    run_single("after_timeout", a, x, b, mac_ref(a, x, b), 1'b0);

    // Reset while waiting on the MAC with a second job queued
    $display("[TB] reset during wait");
    mac_fixed_lat = 6;
    s0 = start_cnt;
    for (int i = 0; i < 2; i++) begin
      a = $urandom;
      x = $urandom;
      b = $urandom;
      apply_stimulus(a, x, b, mac_ref(a, x, b), 1'b0, acc);
    end
    stop_push();
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check_output("rst_wait_start_bound", n >= 20, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    issue_q.delete();
    res_q.delete();
    mac_lat_q.delete();
    model_count = 0;
    #1;
    check_reset_values("midjob_reset");
    @(negedge CLK);
    RST = 1'b0;
    s0 = start_cnt;
    d0 = done_cnt;
    f0 = flush_cnt;
    r0 = result_cnt;
    repeat (15) @(negedge CLK);
    check_output("flush_done_pulses", done_cnt - d0, 1);
    check_output("flush_count", flush_cnt - f0, 1);
    check_output("flush_no_result", result_cnt - r0, 0);
    check_output("flush_no_start", start_cnt - s0, 0);
    check_output("flush_busy", bus.Busy_out, 1'b0);
    mac_fixed_lat = 2;
    a = $urandom;
    x = $urandom;
    b = $urandom;
    run_single("after_flush", a, x, b, mac_ref(a, x, b), 1'b0);

    // Randomised traffic with random MAC latency and random backpressure
    $display("[TB] random traffic");
    mac_mode   = 2;
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      x = $urandom;
      b = $urandom;
      apply_stimulus(a, x, b, mac_ref(a, x, b), 1'b0, acc);
      if ($urandom_range(0, 2) == 0) begin
        stop_push();
        repeat ($urandom_range(1, 6)) @(negedge CLK);
      end
    end
    stop_push();
    wait_drained(3000);
    ready_mode = 0;
    repeat (3) @(negedge CLK);
    check_output("final_issue_q_empty", issue_q.size(), 0);
    check_output("final_busy", bus.Busy_out, 1'b0);
    check_output("final_count", bus.Job_count_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
